layer_mac_array: RTL

- Neuron datapath that sits directly downstream of the layer controller.
- Consumes its layer_start, active, layer_input and layer_weights outputs.
- Returns per-neuron sigmoid-LUT addresses on layer_output and layer_output_valid.
- Each neuron computes a sequential multiply-accumulate over all NUM_NEURON inputs, one input per cycle, then converts the sum to a saturated, offset LUT address.

---
 rtl/layer_mac_array.sv | 134 +++++++++++++
 1 files changed

// File: rtl/layer_mac_array.sv
// rtl/layer_mac_array.sv - sequential per-neuron MAC array producing saturated sigmoid LUT addresses
// Optional build macro LAYER_MAC_SAT_FLAG_EN adds the per-neuron sat_flags output.
module layer_mac_array #(
   parameter int NUM_NEURON      = 6,
   parameter int INPUT_SIZE      = 9,
   parameter int WEIGHT_SIZE     = 17,
   parameter int INPUT_FRACTION  = 8,
   parameter int WEIGHT_FRACTION = 8,
   parameter int FRACTION_BITS   = 7,
   parameter int ADDR_SIZE       = 10
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          start,
   input  logic [NUM_NEURON-1:0]                         active,
   input  logic [NUM_NEURON*INPUT_SIZE-1:0]              inputs,
   input  logic [NUM_NEURON*NUM_NEURON*WEIGHT_SIZE-1:0]  weights,
   output logic [NUM_NEURON*ADDR_SIZE-1:0]               outputs,
   output logic [NUM_NEURON-1:0]                         outputs_valid,
`ifdef LAYER_MAC_SAT_FLAG_EN
   output logic [NUM_NEURON-1:0]                         sat_flags,
`endif
   output logic                                          busy
);

   localparam int PROD_W = INPUT_SIZE + WEIGHT_SIZE + 1;
   localparam int ACC_W  = PROD_W + $clog2(NUM_NEURON);
   localparam int SHIFT  = INPUT_FRACTION + WEIGHT_FRACTION - FRACTION_BITS;
   localparam int K_W    = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
   localparam int HALF   = 1 << (ADDR_SIZE - 1);
   localparam logic [K_W-1:0]          K_LAST = K_W'(NUM_NEURON - 1);
   localparam logic signed [ACC_W-1:0] S_MAX  = ACC_W'(HALF - 1);
   localparam logic signed [ACC_W-1:0] S_MIN  = ACC_W'(-HALF);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                                       state, next_state;
   logic [K_W-1:0]                               k_q;
   logic [NUM_NEURON-1:0]                        act_q;
   logic [NUM_NEURON*INPUT_SIZE-1:0]             in_q;
   logic [NUM_NEURON*NUM_NEURON*WEIGHT_SIZE-1:0] w_q;
   logic signed [ACC_W-1:0]                      acc [NUM_NEURON];
   logic signed [ACC_W-1:0]                      prod [NUM_NEURON];
   logic signed [WEIGHT_SIZE-1:0]                w_sel [NUM_NEURON];
   logic [INPUT_SIZE-1:0]                        x_sel;
   logic signed [ACC_W-1:0]                      s_val, c_val;
   logic [NUM_NEURON-1:0]                        clamp_hi, clamp_lo;
   logic [NUM_NEURON*ADDR_SIZE-1:0]              addr_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE:  if (start) next_state = S_MAC;
         S_MAC:   if (k_q == K_LAST) next_state = S_OUT;
         S_OUT:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Inactive inputs contribute zero, so x_sel is forced to 0 for masked k.
   always_comb begin
      x_sel = '0;
      for (int i = 0; i < NUM_NEURON; i++)
         if (k_q == K_W'(i) && act_q[i]) x_sel = in_q[i*INPUT_SIZE +: INPUT_SIZE];
      for (int j = 0; j < NUM_NEURON; j++) begin
         w_sel[j] = '0;
         for (int k = 0; k < NUM_NEURON; k++)
            if (k_q == K_W'(k)) w_sel[j] = w_q[(j*NUM_NEURON+k)*WEIGHT_SIZE +: WEIGHT_SIZE];
         prod[j] = ACC_W'($signed({1'b0, x_sel})) * ACC_W'(w_sel[j]);
      end
   end

   // Floor shift, clamp to the signed address range, then offset to unsigned.
   always_comb begin
      addr_next = '0;
      clamp_hi  = '0;
      clamp_lo  = '0;
      s_val     = '0;
      c_val     = '0;
      for (int j = 0; j < NUM_NEURON; j++) begin
         s_val       = acc[j] >>> SHIFT;
         clamp_hi[j] = (s_val > S_MAX);
         clamp_lo[j] = (s_val < S_MIN);
         c_val       = clamp_hi[j] ? S_MAX : (clamp_lo[j] ? S_MIN : s_val);
         if (act_q[j]) addr_next[j*ADDR_SIZE +: ADDR_SIZE] = ADDR_SIZE'(c_val + ACC_W'(HALF));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q           <= '0;
         act_q         <= '0;
         in_q          <= '0;
         w_q           <= '0;
         outputs       <= '0;
         outputs_valid <= '0;
         for (int j = 0; j < NUM_NEURON; j++) acc[j] <= '0;
      end else begin
         outputs_valid <= '0;
         case (state)
            S_IDLE: if (start) begin
               in_q  <= inputs;
               w_q   <= weights;
               act_q <= active;
               k_q   <= '0;
               for (int j = 0; j < NUM_NEURON; j++) acc[j] <= '0;
            end
            S_MAC: begin
               for (int j = 0; j < NUM_NEURON; j++) acc[j] <= acc[j] + prod[j];
               k_q <= k_q + 1'b1;
            end
            S_OUT: begin
               outputs       <= addr_next;
               outputs_valid <= '1;
            end
            default: ;
         endcase
      end
   end

`ifdef LAYER_MAC_SAT_FLAG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 sat_flags <= '0;
      else if (state == S_OUT)  sat_flags <= act_q & (clamp_hi | clamp_lo);
   end
`endif

endmodule
